// File: rtl/updn_counter_param_if.sv
// Signal bundle for updn_counter_param: load/count controls in, count and boundary flags out.
// With UDC_ERR_FLAGS_EN defined, also carries clr_flags and the sticky overflow/underflow flags.
interface updn_counter_param_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] data_in;
  logic             ld_cnt;
  logic             count_enb;
  logic             updn_cnt;
  logic             sat_mode;
  logic [WIDTH-1:0] data_out;
  logic             at_max;
  logic             at_min;
  logic             wrap;
`ifdef UDC_ERR_FLAGS_EN
  logic             clr_flags;
  logic             ovf_sticky;
  logic             unf_sticky;

  modport master (
    output data_in, ld_cnt, count_enb, updn_cnt, sat_mode, clr_flags,
    input  data_out, at_max, at_min, wrap, ovf_sticky, unf_sticky
  );

  modport slave (
    input  data_in, ld_cnt, count_enb, updn_cnt, sat_mode, clr_flags,
    output data_out, at_max, at_min, wrap, ovf_sticky, unf_sticky
  );
`else
  modport master (
    output data_in, ld_cnt, count_enb, updn_cnt, sat_mode,
    input  data_out, at_max, at_min, wrap
  );

  modport slave (
    input  data_in, ld_cnt, count_enb, updn_cnt, sat_mode,
    output data_out, at_max, at_min, wrap
  );
`endif
endinterface

// File: rtl/updn_counter_param.sv
// Parametrised up/down counter with modulo limit, step size, wrap/saturate mode and wrap pulse.
// Optional macro UDC_ERR_FLAGS_EN adds sticky overflow/underflow flags cleared by clr_flags.
module updn_counter_param #(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] STEP    = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                 clk,
  input  logic                 rst_,
  updn_counter_param_if.slave  bus
);

  if (WIDTH < 2) begin : g_bad_width
    $error("updn_counter_param: WIDTH must be at least 2");
  end
  if ((STEP == '0) || (STEP > MAX_VAL)) begin : g_bad_step
    $error("updn_counter_param: STEP must lie in 1..MAX_VAL");
  end

  // One extra bit of headroom so c+STEP and c+MAX_VAL+1 never truncate.
  localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX_VAL};
  localparam logic [WIDTH:0] STEP_EXT = {1'b0, STEP};
  localparam logic [WIDTH:0] MOD_EXT = MAX_EXT + {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_nxt;
  logic             wrap_q;
  logic             wrap_nxt;
  logic             ovf_evt;
  logic             unf_evt;

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   up_wrapped;
  logic [WIDTH:0]   down_diff;
  logic [WIDTH:0]   down_wrapped;
  logic             up_over;
  logic             down_under;

  assign cnt_ext      = {1'b0, cnt_q};
  assign up_sum       = cnt_ext + STEP_EXT;
  assign up_over      = up_sum > MAX_EXT;
  assign up_wrapped   = up_sum - MOD_EXT;
  assign down_under   = cnt_ext < STEP_EXT;
  assign down_diff    = cnt_ext - STEP_EXT;
  assign down_wrapped = cnt_ext + MOD_EXT - STEP_EXT;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    cnt_nxt  = cnt_q;
    wrap_nxt = 1'b0;
    ovf_evt  = 1'b0;
    unf_evt  = 1'b0;
    if (!bus.ld_cnt) begin
      cnt_nxt = (bus.data_in > MAX_VAL) ? MAX_VAL : bus.data_in;
    end else if (bus.count_enb) begin
      if (bus.updn_cnt) begin
        ovf_evt = up_over;
        if (!up_over) begin
          cnt_nxt = up_sum[WIDTH-1:0];
        end else if (bus.sat_mode) begin
          cnt_nxt = MAX_VAL;
        end else begin
          cnt_nxt  = up_wrapped[WIDTH-1:0];
          wrap_nxt = 1'b1;
        end
      end else begin
        unf_evt = down_under;
        if (!down_under) begin
          cnt_nxt = down_diff[WIDTH-1:0];
        end else if (bus.sat_mode) begin
          cnt_nxt = '0;
        end else begin
          cnt_nxt  = down_wrapped[WIDTH-1:0];
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign bus.data_out = cnt_q;
  assign bus.wrap     = wrap_q;
  assign bus.at_max   = (cnt_q == MAX_VAL);
  assign bus.at_min   = (cnt_q == '0);

`ifdef UDC_ERR_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  // A boundary crossing on the same edge as clr_flags keeps the flag set.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_evt)             ovf_q <= 1'b1;
      else if (bus.clr_flags)  ovf_q <= 1'b0;
      if (unf_evt)             unf_q <= 1'b1;
      else if (bus.clr_flags)  unf_q <= 1'b0;
    end
  end

  assign bus.ovf_sticky = ovf_q;
  assign bus.unf_sticky = unf_q;
`else
  logic unused_evt;
  assign unused_evt = ovf_evt ^ unf_evt;
`endif

endmodule

// File: tb/tb_updn_counter_param.sv
// Self-checking bench for updn_counter_param (WIDTH=8, MAX_VAL=199, STEP=3): integer model
// checked every negedge plus directed literal expectations; flag tests need UDC_ERR_FLAGS_EN.
module tb_updn_counter_param;
  localparam int W    = 8;
  localparam int MAXV = 199;
  localparam int STP  = 3;

  logic clk = 1'b0;
  logic rst_;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   cmp_en = 1'b0;

  updn_counter_param_if #(.WIDTH(W)) bus ();

  updn_counter_param #(
    .WIDTH  (W),
    .MAX_VAL(8'd199),
    .STEP   (8'd3)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the documented range rules.
  int m_cnt  = 0;
  int m_wrap = 0;
  int m_ovf  = 0;
  int m_unf  = 0;

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      m_cnt <= 0; m_wrap <= 0; m_ovf <= 0; m_unf <= 0;
    end else begin : model_step
      int c, nc, nw, o, u;
      c = m_cnt; nc = c; nw = 0; o = 0; u = 0;
      if (!bus.ld_cnt) begin
        nc = (int'(bus.data_in) > MAXV) ? MAXV : int'(bus.data_in);
      end else if (bus.count_enb) begin
        if (bus.updn_cnt) begin
          o = (c + STP > MAXV) ? 1 : 0;
          if (!o)               nc = c + STP;
          else if (bus.sat_mode) nc = MAXV;
          else begin nc = (c + STP) % (MAXV + 1); nw = 1; end
        end else begin
          u = (c < STP) ? 1 : 0;
          if (!u)               nc = c - STP;
          else if (bus.sat_mode) nc = 0;
          else begin nc = (c - STP + MAXV + 1) % (MAXV + 1); nw = 1; end
        end
      end
      m_cnt  <= nc;
      m_wrap <= nw;
`ifdef UDC_ERR_FLAGS_EN
      m_ovf <= o ? 1 : (bus.clr_flags ? 0 : m_ovf);
      m_unf <= u ? 1 : (bus.clr_flags ? 0 : m_unf);
`endif
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_) begin
      check("model data_out", int'(bus.data_out), m_cnt);
      check("model at_max", int'(bus.at_max), (m_cnt == MAXV) ? 1 : 0);
      check("model at_min", int'(bus.at_min), (m_cnt == 0) ? 1 : 0);
      check("model wrap", int'(bus.wrap), m_wrap);
`ifdef UDC_ERR_FLAGS_EN
      check("model ovf_sticky", int'(bus.ovf_sticky), m_ovf);
      check("model unf_sticky", int'(bus.unf_sticky), m_unf);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit ld, input int din, input bit enb, input bit up, input bit sat);
    bus.ld_cnt    = ld;
    bus.data_in   = W'(din);
    bus.count_enb = enb;
    bus.updn_cnt  = up;
    bus.sat_mode  = sat;
  endtask

  task automatic expect_out(input string tag, input int cnt, input int w);
    check({tag, " data_out"}, int'(bus.data_out), cnt);
    check({tag, " wrap"}, int'(bus.wrap), w);
  endtask

  initial begin
    rst_ = 1'b0;
    drive(1'b1, 0, 1'b0, 1'b1, 1'b0);
`ifdef UDC_ERR_FLAGS_EN
    bus.clr_flags = 1'b0;
`endif
    step(); step();
    expect_out("reset", 0, 0);
    check("reset at_min", int'(bus.at_min), 1);
    check("reset at_max", int'(bus.at_max), 0);
    @(negedge clk);
    rst_ = 1'b1;
    cmp_en = 1'b1;

    // Async reset mid-count at 57
    drive(1'b0, 54, 1'b0, 1'b1, 1'b0); step();
    expect_out("load 54", 54, 0);
    drive(1'b1, 0, 1'b1, 1'b1, 1'b0); step();
    expect_out("up to 57", 57, 0);
    drive(1'b1, 0, 1'b0, 1'b1, 1'b0);
    rst_ = 1'b0;
    #1;
    expect_out("async reset", 0, 0);
    check("async reset at_min", int'(bus.at_min), 1);
    #2;
    rst_ = 1'b1;

    // Load clamp to MAX_VAL, then normal load
    drive(1'b0, 250, 1'b0, 1'b1, 1'b0); step();
    expect_out("load clamp", 199, 0);
    check("load clamp at_max", int'(bus.at_max), 1);
    drive(1'b0, 10, 1'b0, 1'b1, 1'b0); step();
    expect_out("load 10", 10, 0);

    // Up wrap from 198
    drive(1'b0, 198, 1'b0, 1'b1, 1'b0); step();
    drive(1'b1, 0, 1'b1, 1'b1, 1'b0); step();
    expect_out("up wrap", 1, 1);
    step();
    expect_out("after up wrap", 4, 0);

    // Down wrap from 1, then down saturate
    drive(1'b0, 1, 1'b0, 1'b1, 1'b0); step();
    drive(1'b1, 0, 1'b1, 1'b0, 1'b0); step();
    expect_out("down wrap", 198, 1);
    drive(1'b0, 1, 1'b0, 1'b1, 1'b0); step();
    drive(1'b1, 0, 1'b1, 1'b0, 1'b1); step();
    expect_out("down sat", 0, 0);
    step();
    expect_out("down sat hold", 0, 0);

    // Hold for 5 edges, then load beats count
    drive(1'b0, 77, 1'b0, 1'b1, 1'b0); step();
    drive(1'b1, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("hold 77", 77, 0);
    end
    drive(1'b0, 5, 1'b1, 1'b1, 1'b0); step();
    expect_out("load wins", 5, 0);

    // Up saturate at MAX_VAL, then switch to wrap mode at the boundary
    drive(1'b0, 198, 1'b0, 1'b1, 1'b0); step();
    drive(1'b1, 0, 1'b1, 1'b1, 1'b1); step();
    expect_out("up sat", 199, 0);
    step();
    expect_out("up sat hold", 199, 0);
    drive(1'b1, 0, 1'b1, 1'b1, 1'b0); step();
    expect_out("wrap from max", 2, 1);

`ifdef UDC_ERR_FLAGS_EN
    bus.clr_flags = 1'b1;
    drive(1'b0, 198, 1'b0, 1'b1, 1'b0); step();
    check("flags cleared ovf", int'(bus.ovf_sticky), 0);
    bus.clr_flags = 1'b0;
    drive(1'b1, 0, 1'b1, 1'b1, 1'b1); step();
    check("ovf set", int'(bus.ovf_sticky), 1);
    bus.clr_flags = 1'b1; step();
    check("ovf set wins over clr", int'(bus.ovf_sticky), 1);
    drive(1'b1, 0, 1'b0, 1'b1, 1'b1); step();
    check("ovf cleared", int'(bus.ovf_sticky), 0);
    bus.clr_flags = 1'b0;
    drive(1'b0, 2, 1'b0, 1'b1, 1'b0); step();
    check("load no unf", int'(bus.unf_sticky), 0);
    drive(1'b1, 0, 1'b1, 1'b0, 1'b1); step();
    check("unf set", int'(bus.unf_sticky), 1);
    check("unf sat value", int'(bus.data_out), 0);
`endif

    // Mixed traffic checked by the model only
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) != 0), int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`ifdef UDC_ERR_FLAGS_EN
      bus.clr_flags = ($urandom_range(0, 15) == 0);
`endif
      step();
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
